locker_access_scheduler: RTL

- Shares the single takeaway-locker core among NREQ front-panel terminals (courier and customer keypads).
- Each terminal posts a deposit or retrieve request with a 4-bit key.
- The scheduler arbitrates round-robin, sequences one core transaction at a time (start / wait-for-done / release), enforces a response timeout, and locks the whole cabinet out after repeated wrong retrieve keys.
- It sits between the terminal interfaces and the locker core's func/key/start inputs.

---
 rtl/locker_access_scheduler.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/locker_access_scheduler.sv
// Round-robin scheduler sharing the takeaway-locker core among NREQ terminals.
// Sequences one core transaction at a time with a response timeout and a wrong-key lockout.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | no transaction; picks the next requester round-robin
// S_ISSUE     | grant asserted; start pulse to the core if the opcode is valid
// S_WAIT_CORE | waiting for core_done, bounded by TIMEOUT cycles
// S_RELEASE   | done/err pulse to the owner; fail counter update
// S_LOCKOUT   | cabinet locked for LOCK_CYCLES cycles; requests ignored
module locker_access_scheduler #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT     = 255,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [4*NREQ-1:0] key_in,
  input  logic              core_done,
  input  logic              core_ok,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic [1:0]        core_func,
  output logic [3:0]        core_key,
  output logic              core_start,
  output logic              timeout_flag,
  output logic              lockout,
  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CORE,
    S_RELEASE,
    S_LOCKOUT
  } state_t;

  localparam logic [1:0]  OP_DEP    = 2'b01;
  localparam logic [1:0]  OP_RET    = 2'b10;
  localparam logic [2:0]  NREQ3     = 3'(NREQ);
  localparam logic [7:0]  TMO8      = 8'(TIMEOUT);
  localparam logic [2:0]  MAXF3     = 3'(MAX_FAIL);
  localparam logic [15:0] LOCK16    = 16'(LOCK_CYCLES - 1);
  localparam logic [1:0]  OWNER_RST = 2'(NREQ - 1);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  key_q, key_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [15:0] lock_q, lock_d;
  logic [2:0]  fail_q, fail_d;
  logic        rec_err_q, rec_err_d;
  logic        rec_tmo_q, rec_tmo_d;
  logic        tflag_q, tflag_d;

  logic [3:0]  req_ext;
  logic [7:0]  op_ext;
  logic [15:0] key_ext;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [2:0]  cand;
  logic [2:0]  fail_nxt;
  logic        op_valid;
  logic        granted;
  logic [3:0]  owner_oh;

  // Terminal fields padded to the 4-terminal maximum so the 2-bit owner can index them.
  always_comb begin
    req_ext = '0;
    op_ext  = '0;
    key_ext = '0;
    req_ext[NREQ-1:0]   = req;
    op_ext[2*NREQ-1:0]  = op;
    key_ext[4*NREQ-1:0] = key_in;
  end

  // First requester searching upward from owner+1, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = owner_q;
    cand       = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = 3'(owner_q) + 3'(i);
      if (cand >= NREQ3) begin
        cand = cand - NREQ3;
      end
      if (!pick_valid && req_ext[cand[1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[1:0];
      end
    end
  end

  assign op_valid = (op_q == OP_DEP) || (op_q == OP_RET);

  always_comb begin
    fail_nxt = fail_q;
    if ((op_q == OP_RET) && !rec_tmo_q) begin
      if (rec_err_q) begin
        fail_nxt = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
      end else begin
        fail_nxt = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    key_d     = key_q;
    tmr_d     = tmr_q;
    lock_d    = lock_q;
    fail_d    = fail_q;
    rec_err_d = rec_err_q;
    rec_tmo_d = rec_tmo_q;
    tflag_d   = tflag_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          op_d    = op_ext[{pick_idx, 1'b0} +: 2];
          key_d   = key_ext[{pick_idx, 2'b00} +: 4];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rec_tmo_d = 1'b0;
        if (op_valid) begin
          rec_err_d = 1'b0;
          tmr_d     = 8'd1;
          state_d   = S_WAIT_CORE;
        end else begin
          rec_err_d = 1'b1;
          state_d   = S_RELEASE;
        end
      end
      S_WAIT_CORE: begin
        // A response arriving on the timeout cycle still counts as a response.
        if (core_done) begin
          rec_err_d = !core_ok;
          state_d   = S_RELEASE;
        end else if (tmr_q == TMO8) begin
          rec_err_d = 1'b1;
          rec_tmo_d = 1'b1;
          tflag_d   = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      S_RELEASE: begin
        tmr_d = '0;
        if (fail_nxt >= MAXF3) begin
          fail_d  = '0;
          lock_d  = LOCK16;
          state_d = S_LOCKOUT;
        end else begin
          fail_d  = fail_nxt;
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (lock_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= OWNER_RST;
      op_q      <= '0;
      key_q     <= '0;
      tmr_q     <= '0;
      lock_q    <= '0;
      fail_q    <= '0;
      rec_err_q <= 1'b0;
      rec_tmo_q <= 1'b0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      key_q     <= key_d;
      tmr_q     <= tmr_d;
      lock_q    <= lock_d;
      fail_q    <= fail_d;
      rec_err_q <= rec_err_d;
      rec_tmo_q <= rec_tmo_d;
      tflag_q   <= tflag_d;
    end
  end

  assign granted  = (state_q == S_ISSUE) || (state_q == S_WAIT_CORE) || (state_q == S_RELEASE);
  assign owner_oh = 4'b0001 << owner_q;

  // Invalid opcodes are never presented to the core.
  assign gnt          = granted ? owner_oh[NREQ-1:0] : '0;
  assign done         = (state_q == S_RELEASE) ? owner_oh[NREQ-1:0] : '0;
  assign err          = ((state_q == S_RELEASE) && rec_err_q) ? owner_oh[NREQ-1:0] : '0;
  assign core_func    = (granted && op_valid) ? op_q : 2'b00;
  assign core_key     = (granted && op_valid) ? key_q : 4'b0000;
  assign core_start   = (state_q == S_ISSUE) && op_valid;
  assign timeout_flag = tflag_q;
  assign lockout      = (state_q == S_LOCKOUT);
  assign busy         = (state_q != S_IDLE);
  assign owner        = owner_q;

endmodule
